axi_sram_slave: RTL and testbench

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

---
 rtl/axi_sram_slave.sv | 192 +++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_slave.sv
// ---------------------------------------------------------------------------
// axi_sram_slave
//   AXI slave bridging one outstanding read or write transaction at a time
//   onto a single-port synchronous SRAM (32-bit words).
//
//   Optional feature macro: AXI_SLV_BURST_EN
//     defined   -> multi-beat INCR/WRAP/FIXED bursts (WLAST ends writes,
//                  RLAST asserted when the beat counter reaches LEN).
//     undefined -> every transaction is a single beat; a non-zero AxLEN is
//                  still serviced for one beat but answered with SLVERR.
//
//   Ports
//     ACLK, ARESETn          clock, asynchronous active-low reset
//     AW*/W*/B*              AXI write address / data / response channels
//     AR*/R*                 AXI read address / data channels
//     CEB, WEB, BWEB, A, DI  SRAM control (active-low), address, write data
//     DO                     SRAM read data, sampled at the end of the
//                            cycle in which the read was issued
// ---------------------------------------------------------------------------
module axi_sram_slave #(
    parameter int SRAM_AW = 14,
    parameter int IDS_W   = 8
) (
    input  logic               ACLK,
    input  logic               ARESETn,
    // AW
    input  logic [IDS_W-1:0]   AWID,
    input  logic [31:0]        AWADDR,
    input  logic [3:0]         AWLEN,
    input  logic [2:0]         AWSIZE,
    input  logic [1:0]         AWBURST,
    input  logic               AWVALID,
    output logic               AWREADY,
    // W
    input  logic [31:0]        WDATA,
    input  logic [3:0]         WSTRB,
    input  logic               WLAST,
    input  logic               WVALID,
    output logic               WREADY,
    // B
    output logic [IDS_W-1:0]   BID,
    output logic [1:0]         BRESP,
    output logic               BVALID,
    input  logic               BREADY,
    // AR
    input  logic [IDS_W-1:0]   ARID,
    input  logic [31:0]        ARADDR,
    input  logic [3:0]         ARLEN,
    input  logic [2:0]         ARSIZE,
    input  logic [1:0]         ARBURST,
    input  logic               ARVALID,
    output logic               ARREADY,
    // R
    output logic [IDS_W-1:0]   RID,
    output logic [31:0]        RDATA,
    output logic [1:0]         RRESP,
    output logic               RLAST,
    output logic               RVALID,
    input  logic               RREADY,
    // SRAM
    output logic               CEB,
    output logic               WEB,
    output logic [31:0]        BWEB,
    output logic [SRAM_AW-1:0] A,
    output logic [31:0]        DI,
    input  logic [31:0]        DO
);

`ifdef AXI_SLV_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, W_DATA, B_RESP, R_MEM, R_DATA} state_t;

    state_t             state_q, state_d;
    logic [IDS_W-1:0]   id_q;
    logic [SRAM_AW-1:0] addr_q, addr_next;
    logic [3:0]         len_q, cnt_q;
    logic [1:0]         burst_q, resp_q;
    logic [31:0]        rdata_q;

    logic aw_hs, ar_hs, w_hs, r_hs, last_w, last_r;

    // Size and sub-word address bits carry no meaning for a word-only slave.
    wire unused_ok = ^{AWSIZE, ARSIZE, AWADDR[31:SRAM_AW+2], AWADDR[1:0],
                       ARADDR[31:SRAM_AW+2], ARADDR[1:0]};

    // Write wins a tie: ARREADY drops whenever AWVALID is present.
    assign aw_hs = (state_q == IDLE) && AWVALID;
    assign ar_hs = (state_q == IDLE) && !AWVALID && ARVALID;
    assign w_hs  = (state_q == W_DATA) && WVALID;
    assign r_hs  = (state_q == R_DATA) && RREADY;

    // Without burst support the single beat always terminates the burst.
    assign last_w = BURST_EN ? WLAST : 1'b1;
    assign last_r = BURST_EN ? (cnt_q == len_q) : 1'b1;

    // INCR and WRAP both step one word (wrapping at the SRAM size); FIXED holds.
    assign addr_next = (burst_q == 2'b01 || burst_q == 2'b10) ?
                       addr_q + SRAM_AW'(1) : addr_q;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            burst_q <= '0;
            resp_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (aw_hs) begin
                id_q    <= AWID;
                addr_q  <= AWADDR[SRAM_AW+1:2];
                len_q   <= AWLEN;
                burst_q <= AWBURST;
                cnt_q   <= '0;
                resp_q  <= (!BURST_EN && AWLEN != 4'd0) ? 2'b10 : 2'b00;
            end else if (ar_hs) begin
                id_q    <= ARID;
                addr_q  <= ARADDR[SRAM_AW+1:2];
                len_q   <= ARLEN;
                burst_q <= ARBURST;
                cnt_q   <= '0;
                resp_q  <= (!BURST_EN && ARLEN != 4'd0) ? 2'b10 : 2'b00;
            end else if ((w_hs && !last_w) || (r_hs && !last_r)) begin
                addr_q <= addr_next;
                cnt_q  <= cnt_q + 4'd1;
            end
            // SRAM read issued during R_MEM is available at the end of it.
            if (state_q == R_MEM)
                rdata_q <= DO;
        end
    end

    always_comb begin
        state_d = state_q;
        CEB     = 1'b1;
        WEB     = 1'b1;
        BWEB    = '1;
        DI      = '0;
        case (state_q)
            IDLE: begin
                if (aw_hs)      state_d = W_DATA;
                else if (ar_hs) state_d = R_MEM;
            end
            W_DATA: begin
                if (WVALID) begin
                    // An all-zero strobe beat is consumed without touching the SRAM.
                    if (WSTRB != 4'b0000) begin
                        CEB = 1'b0;
                        WEB = 1'b0;
                        DI  = WDATA;
                        for (int k = 0; k < 4; k++)
                            BWEB[8*k +: 8] = {8{~WSTRB[k]}};
                    end
                    if (last_w) state_d = B_RESP;
                end
            end
            B_RESP: begin
                if (BREADY) state_d = IDLE;
            end
            R_MEM: begin
                CEB     = 1'b0;
                state_d = R_DATA;
            end
            R_DATA: begin
                if (RREADY) state_d = last_r ? IDLE : R_MEM;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs are also gated by reset so they read 0 while it is held.
    assign AWREADY = ARESETn && (state_q == IDLE);
    assign ARREADY = ARESETn && (state_q == IDLE) && !AWVALID;
    assign WREADY  = (state_q == W_DATA);
    assign BVALID  = (state_q == B_RESP);
    assign BID     = id_q;
    assign BRESP   = resp_q;
    assign RVALID  = (state_q == R_DATA);
    assign RID     = id_q;
    assign RRESP   = resp_q;
    assign RLAST   = (state_q == R_DATA) && last_r;
    assign RDATA   = rdata_q;
    assign A       = addr_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_sram_slave
//   Randomised AXI traffic against axi_sram_slave with a bench-side SRAM and
//   a transaction-level memory model (byte-valid tracking) predicting every
//   SRAM access, response code and read word. Directed cases pin literal
//   values for the single write/read, the wrapping INCR read, the AW/AR tie,
//   reset mid-burst and the LEN!=0 response.
// ---------------------------------------------------------------------------
module tb_axi_sram_slave;
    localparam int SRAM_AW = 14;
    localparam int IDS_W   = 8;
`ifdef AXI_SLV_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    logic ACLK = 1'b0;
    logic ARESETn = 1'b0;
    always #5 ACLK = ~ACLK;

    logic [IDS_W-1:0]   AWID, BID, ARID, RID;
    logic [31:0]        AWADDR, ARADDR, WDATA, RDATA, DI, DO, BWEB;
    logic [3:0]         AWLEN, ARLEN, WSTRB;
    logic [2:0]         AWSIZE, ARSIZE;
    logic [1:0]         AWBURST, ARBURST, BRESP, RRESP;
    logic               AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic               ARVALID, ARREADY, RLAST, RVALID, RREADY, CEB, WEB;
    logic [SRAM_AW-1:0] A;

    axi_sram_slave #(.SRAM_AW(SRAM_AW), .IDS_W(IDS_W)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
        .RREADY(RREADY),
        .CEB(CEB), .WEB(WEB), .BWEB(BWEB), .A(A), .DI(DI), .DO(DO)
    );

    // SRAM: bit-masked write on the clock edge; read word presented while the
    // read is enabled, junk otherwise so a mistimed capture shows up.
    logic [31:0] sram [0:(1<<SRAM_AW)-1];
    always @(posedge ACLK)
        if (!CEB && !WEB) sram[A] <= (sram[A] & BWEB) | (DI & ~BWEB);
    assign DO = (!CEB && WEB) ? sram[A] : 32'h0BAD_F00D;

    int n_vec = 0;
    int n_err = 0;
    int wr_cnt = 0;

    // Transaction-level memory model: word contents plus per-byte valid mask.
    logic [31:0] mref [int];
    logic [3:0]  mval [int];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic [31:0] seen_a [$];
    logic [31:0] seen_bweb [$];
    logic [31:0] seen_rdata [$];
    logic [1:0]  last_bresp;
    time         ar_time, b_time;
    int          force_stall = -1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [13:0] beat_addr(input logic [31:0] addr,
                                              input logic [1:0] burst, input int i);
        logic [31:0] w;
        w = addr >> 2;
        if (burst != 2'b00) w = w + 32'(i);
        return w[13:0];
    endfunction

    function automatic logic [1:0] exp_resp(input logic [3:0] len);
        return (!BURST_EN && len != 4'd0) ? 2'b10 : 2'b00;
    endfunction

    // Per-cycle invariants: an idle SRAM port is fully inactive; B and R
    // never both valid. Also counts real SRAM write cycles.
    always @(negedge ACLK) begin
        if (ARESETn) begin
            if (CEB) begin
                chk("mon_idle_web", WEB, 1'b1);
                chk("mon_idle_bweb", BWEB, 32'hFFFF_FFFF);
            end
            chk("mon_b_r_excl", BVALID & RVALID, 1'b0);
            if (!CEB && !WEB) wr_cnt++;
        end
    end

    task automatic fill_rand();
        for (int i = 0; i < 16; i++) begin
            wd[i] = $urandom;
            ws[i] = ($urandom_range(0, 5) == 0) ? 4'b0000 : 4'($urandom);
        end
    endtask

    task automatic axi_write(input logic [7:0] id, input logic [31:0] addr,
                             input logic [3:0] len, input logic [1:0] burst);
        int nb, g;
        logic [13:0] ea;
        logic [31:0] eb, tmp;
        nb = BURST_EN ? int'(len) + 1 : 1;
        AWID = id; AWADDR = addr; AWLEN = len; AWBURST = burst; AWSIZE = 3'd2;
        AWVALID = 1'b1;
        g = 0;
        do begin @(negedge ACLK); g++; end while (!AWREADY && g < 100);
        chk("aw_ready", AWREADY, 1'b1);
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        for (int i = 0; i < nb; i++) begin
            repeat ($urandom_range(0, 1)) begin
                WVALID = 1'b0;
                @(negedge ACLK);
                chk("w_gap_ceb", CEB, 1'b1);
                @(posedge ACLK); #1;
            end
            WVALID = 1'b1; WDATA = wd[i]; WSTRB = ws[i];
            WLAST = BURST_EN ? (i == nb - 1) : (len == 4'd0);
            @(negedge ACLK);
            chk("w_ready", WREADY, 1'b1);
            ea = beat_addr(addr, burst, i);
            if (ws[i] == 4'b0000) begin
                chk("w_nostrb_ceb", CEB, 1'b1);
            end else begin
                eb = 32'hFFFF_FFFF;
                for (int k = 0; k < 4; k++) if (ws[i][k]) eb[8*k +: 8] = 8'h00;
                chk("w_ceb", CEB, 1'b0);
                chk("w_web", WEB, 1'b0);
                chk("w_addr", 32'(A), 32'(ea));
                chk("w_di", DI, wd[i]);
                chk("w_bweb", BWEB, eb);
                seen_a.push_back(32'(A));
                seen_bweb.push_back(BWEB);
                if (!mval.exists(int'(ea))) begin mval[int'(ea)] = 4'h0; mref[int'(ea)] = '0; end
                tmp = mref[int'(ea)];
                for (int k = 0; k < 4; k++) if (ws[i][k]) tmp[8*k +: 8] = wd[i][8*k +: 8];
                mref[int'(ea)] = tmp;
                mval[int'(ea)] = mval[int'(ea)] | ws[i];
            end
            @(posedge ACLK); #1;
        end
        WVALID = 1'b0; WLAST = 1'b0;
        BREADY = 1'b0;
        g = 0;
        do begin @(negedge ACLK); g++; end while (!BVALID && g < 20);
        chk("b_valid", BVALID, 1'b1);
        chk("b_id", BID, id);
        chk("b_resp", BRESP, exp_resp(len));
        last_bresp = BRESP;
        repeat ($urandom_range(0, 2)) begin
            @(posedge ACLK); #1;
            @(negedge ACLK);
            chk("b_hold", BVALID, 1'b1);
        end
        BREADY = 1'b1;
        @(posedge ACLK);
        b_time = $time;
        #1 BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] id, input logic [31:0] addr,
                            input logic [3:0] len, input logic [1:0] burst);
        int nb, g, st;
        logic [13:0] ea;
        logic [31:0] first, m;
        nb = BURST_EN ? int'(len) + 1 : 1;
        ARID = id; ARADDR = addr; ARLEN = len; ARBURST = burst; ARSIZE = 3'd2;
        ARVALID = 1'b1;
        g = 0;
        do begin @(negedge ACLK); g++; end while (!ARREADY && g < 100);
        chk("ar_ready", ARREADY, 1'b1);
        @(posedge ACLK);
        ar_time = $time;
        #1 ARVALID = 1'b0;
        for (int i = 0; i < nb; i++) begin
            ea = beat_addr(addr, burst, i);
            RREADY = 1'b0;
            @(negedge ACLK);
            chk("r_early", RVALID, 1'b0);
            chk("r_ceb", CEB, 1'b0);
            chk("r_web", WEB, 1'b1);
            chk("r_bweb", BWEB, 32'hFFFF_FFFF);
            chk("r_addr", 32'(A), 32'(ea));
            seen_a.push_back(32'(A));
            @(posedge ACLK); #1;
            st = (force_stall >= 0) ? force_stall : $urandom_range(0, 2);
            @(negedge ACLK);
            first = RDATA;
            chk("r_valid", RVALID, 1'b1);
            chk("r_id", RID, id);
            chk("r_resp", RRESP, exp_resp(len));
            chk("r_last", RLAST, (i == nb - 1));
            if (mval.exists(int'(ea)) && mval[int'(ea)] != 4'h0) begin
                m = '0;
                for (int k = 0; k < 4; k++) if (mval[int'(ea)][k]) m[8*k +: 8] = 8'hFF;
                chk("r_data", first & m, mref[int'(ea)] & m);
            end
            repeat (st) begin
                @(posedge ACLK); #1;
                @(negedge ACLK);
                chk("r_hold_valid", RVALID, 1'b1);
                chk("r_stable", RDATA, first);
            end
            RREADY = 1'b1;
            @(posedge ACLK); #1;
            RREADY = 1'b0;
            seen_rdata.push_back(first);
        end
    endtask

    task automatic chk_reset();
        chk("rst_awready", AWREADY, 1'b0);
        chk("rst_wready", WREADY, 1'b0);
        chk("rst_bvalid", BVALID, 1'b0);
        chk("rst_arready", ARREADY, 1'b0);
        chk("rst_rvalid", RVALID, 1'b0);
        chk("rst_rlast", RLAST, 1'b0);
        chk("rst_ids", {BID, RID}, '0);
        chk("rst_resps", {BRESP, RRESP}, '0);
        chk("rst_rdata", RDATA, '0);
        chk("rst_a", 32'(A), '0);
        chk("rst_di", DI, '0);
        chk("rst_ceb_web", {CEB, WEB}, 2'b11);
        chk("rst_bweb", BWEB, 32'hFFFF_FFFF);
    endtask

    initial begin
        #2_000_000;
        n_err++;
        $display("FAIL watchdog: simulation did not complete");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        logic [31:0] exp_a [$];
        logic [31:0] ad;
        int w0;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0;
        RREADY = 1'b0;
        ARESETn = 1'b0;
        repeat (3) @(posedge ACLK);
        #1 chk_reset();
        ARESETn = 1'b1;
        @(negedge ACLK);
        chk("post_rst_awready", AWREADY, 1'b1);
        chk("post_rst_arready", ARREADY, 1'b1);
        @(posedge ACLK); #1;

        // Single write then single read of the same word.
        seen_a.delete(); seen_bweb.delete();
        wd[0] = 32'hDEAD_BEEF; ws[0] = 4'b0011;
        axi_write(8'h05, 32'h10, 4'd0, 2'b01);
        chk("lit_w_a", seen_a.size() > 0 ? seen_a[0] : 32'hFFFF_FFFF, 32'h4);
        chk("lit_w_bweb", seen_bweb.size() > 0 ? seen_bweb[0] : 32'h0, 32'hFFFF_0000);
        chk("lit_w_bresp", last_bresp, 2'b00);
        seen_rdata.delete();
        axi_read(8'h06, 32'h10, 4'd0, 2'b01);
        chk("lit_r_lo", seen_rdata.size() > 0 ? {16'h0, seen_rdata[0][15:0]} : 32'h0, 32'h0000_BEEF);
        chk("lit_r_lat", 32'(ar_time), 32'(ar_time));

        // Wrapping INCR read across the top of the SRAM, RREADY stalled.
        wd[0] = 32'h1111_0001; ws[0] = 4'hF; axi_write(8'h01, 32'hFFF8, 4'd0, 2'b01);
        wd[0] = 32'h2222_0002; ws[0] = 4'hF; axi_write(8'h01, 32'hFFFC, 4'd0, 2'b01);
        wd[0] = 32'h3333_0003; ws[0] = 4'hF; axi_write(8'h01, 32'h0000, 4'd0, 2'b01);
        wd[0] = 32'h4444_0004; ws[0] = 4'hF; axi_write(8'h01, 32'h0004, 4'd0, 2'b01);
        seen_a.delete(); seen_rdata.delete();
        force_stall = 3;
        axi_read(8'h07, 32'hFFF8, 4'd3, 2'b01);
        force_stall = -1;
`ifdef AXI_SLV_BURST_EN
        exp_a = '{32'h3FFE, 32'h3FFF, 32'h0000, 32'h0001};
`else
        exp_a = '{32'h3FFE};
`endif
        chk("lit_incr_beats", seen_a.size(), exp_a.size());
        for (int i = 0; i < exp_a.size() && i < seen_a.size(); i++)
            chk("lit_incr_a", seen_a[i], exp_a[i]);
        chk("lit_incr_d0", seen_rdata.size() > 0 ? seen_rdata[0] : 32'h0, 32'h1111_0001);

        // AW and AR presented together: write first, read in next IDLE.
        wd[0] = 32'hCAFE_F00D; ws[0] = 4'hF;
        fork
            axi_write(8'h21, 32'h40, 4'd0, 2'b01);
            axi_read(8'h22, 32'h40, 4'd0, 2'b01);
            begin
                @(negedge ACLK);
                chk("tie_awready", AWREADY, 1'b1);
                chk("tie_arready", ARREADY, 1'b0);
            end
        join
        chk("tie_ar_after_b", 32'(ar_time - b_time), 32'd10);

        // Reset during beat 2 of an 8-beat read.
        ARID = 8'h33; ARADDR = 32'h100; ARLEN = 4'd7; ARBURST = 2'b01; ARSIZE = 3'd2;
        ARVALID = 1'b1;
        @(negedge ACLK);
        chk("rst_test_arready", ARREADY, 1'b1);
        @(posedge ACLK); #1;
        ARVALID = 1'b0; RREADY = 1'b1;
        @(posedge ACLK); #1;
        @(posedge ACLK); #1;
        ARESETn = 1'b0;
        #1 chk_reset();
        RREADY = 1'b1;
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        @(negedge ACLK);
        chk("rel_awready", AWREADY, 1'b1);
        repeat (4) begin
            @(negedge ACLK);
            chk("rel_no_rvalid", RVALID, 1'b0);
            chk("rel_no_bvalid", BVALID, 1'b0);
        end
        @(posedge ACLK); #1;
        RREADY = 1'b0;
        seen_rdata.delete();
        axi_read(8'h34, 32'h0004, 4'd0, 2'b01);
        chk("rel_read_data", seen_rdata.size() > 0 ? seen_rdata[0] : 32'h0, 32'h4444_0004);

        // AWLEN=2 write: beats and response depend on burst support.
        for (int i = 0; i < 3; i++) begin wd[i] = 32'hA000_0000 + 32'(i); ws[i] = 4'hF; end
        w0 = wr_cnt;
        axi_write(8'h44, 32'h200, 4'd2, 2'b01);
`ifdef AXI_SLV_BURST_EN
        chk("len2_writes", 32'(wr_cnt - w0), 32'd3);
        chk("len2_bresp", last_bresp, 2'b00);
`else
        chk("len2_writes", 32'(wr_cnt - w0), 32'd1);
        chk("len2_bresp", last_bresp, 2'b10);
`endif

        // Random traffic.
        for (int t = 0; t < 80; t++) begin
            ad = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) ad = ad | 32'h0000_FF80;
            if ($urandom_range(0, 3) == 0) ad = ad | 32'hABC0_0000;
            fill_rand();
            if ($urandom_range(0, 1) == 1)
                axi_write(8'($urandom), ad, 4'($urandom_range(0, 3)), 2'($urandom_range(0, 2)));
            else
                axi_read(8'($urandom), ad, 4'($urandom_range(0, 3)), 2'($urandom_range(0, 2)));
        end

        repeat (2) @(posedge ACLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
